// File: rtl/multicycle_control_if.sv
// Start/halt, fetch handshake and datapath control bundle of the multicycle sequencer.
interface multicycle_control_if;
    logic        start;
    logic        halt;
    logic [31:0] instr;
    logic        instr_valid;
    logic        imem_req;
    logic        pc_write;
    logic        reg_dst;
    logic        reg_write;
    logic        ex_top;
    logic        alu_src;
    logic        mem_write;
    logic        mem2reg;
    logic [3:0]  alu_op;
    logic        illegal;
    logic        busy;
    logic [15:0] instr_cnt;

    modport master (
        output start, halt, instr, instr_valid,
        input  imem_req, pc_write, reg_dst, reg_write, ex_top, alu_src,
               mem_write, mem2reg, alu_op, illegal, busy, instr_cnt
    );

    modport slave (
        input  start, halt, instr, instr_valid,
        output imem_req, pc_write, reg_dst, reg_write, ex_top, alu_src,
               mem_write, mem2reg, alu_op, illegal, busy, instr_cnt
    );
endinterface

// File: rtl/multicycle_control.sv
// Five-state fetch/decode/execute/writeback sequencer with registered datapath controls
// and a 16-bit retired-instruction counter.
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

    typedef struct packed {
        logic       legal;
        logic       reg_dst;
        logic       alu_src;
        logic       ex_top;
        logic [3:0] alu_op;
    } dec_t;

    state_t      state;
    logic [11:0] ir;
    logic [15:0] retired;
    logic [11:0] decode_src;
    dec_t        dec;

    function automatic dec_t decode(input logic [11:0] w);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (w[11:6])
            6'b000000: begin
                d.reg_dst = 1'b1;
                case (w[5:0])
                    6'b100000: d.alu_op = 4'b0010;
                    6'b100010: d.alu_op = 4'b0110;
                    6'b100100: d.alu_op = 4'b0000;
                    6'b100101: d.alu_op = 4'b0001;
                    6'b101010: d.alu_op = 4'b0111;
                    default:   d.legal  = 1'b0;
                endcase
            end
            6'b001000: begin
                d.alu_src = 1'b1;
                d.ex_top  = 1'b1;
                d.alu_op  = 4'b0010;
            end
            6'b011001: begin
                d.alu_src = 1'b1;
                d.alu_op  = 4'b1000;
            end
            6'b011000: begin
                d.alu_src = 1'b1;
                d.alu_op  = 4'b1001;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // IR keeps only opcode and funct; in FETCH the incoming word is judged so that
    // ILLEGAL can already be registered for the DECODE cycle.
    assign decode_src    = (state == FETCH) ? {bus.instr[31:26], bus.instr[5:0]} : ir;
    assign dec           = decode(decode_src);
    assign bus.instr_cnt = retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ir            <= '0;
            retired       <= '0;
            bus.imem_req  <= 1'b0;
            bus.pc_write  <= 1'b0;
            bus.reg_dst   <= 1'b0;
            bus.reg_write <= 1'b0;
            bus.ex_top    <= 1'b0;
            bus.alu_src   <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem2reg   <= 1'b0;
            bus.alu_op    <= 4'b0000;
            bus.illegal   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.imem_req  <= 1'b0;
            bus.pc_write  <= 1'b0;
            bus.reg_dst   <= 1'b0;
            bus.reg_write <= 1'b0;
            bus.ex_top    <= 1'b0;
            bus.alu_src   <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem2reg   <= 1'b0;
            bus.alu_op    <= 4'b0000;
            bus.illegal   <= 1'b0;
            bus.busy      <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= FETCH;
                        bus.imem_req <= 1'b1;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.instr_valid) begin
                        ir    <= decode_src;
                        state <= DECODE;
                        if (!dec.legal) begin
                            bus.illegal  <= 1'b1;
                            bus.pc_write <= 1'b1;
                        end
                    end else begin
                        bus.imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    if (dec.legal) begin
                        state       <= EXEC;
                        bus.reg_dst <= dec.reg_dst;
                        bus.alu_src <= dec.alu_src;
                        bus.ex_top  <= dec.ex_top;
                        bus.alu_op  <= dec.alu_op;
                        bus.mem2reg <= 1'b1;
                    end else if (bus.halt) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state        <= FETCH;
                        bus.imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    // Counter moves on entry to WB so the new value is visible with REG_WRITE.
                    state         <= WB;
                    bus.reg_dst   <= bus.reg_dst;
                    bus.alu_src   <= bus.alu_src;
                    bus.ex_top    <= bus.ex_top;
                    bus.alu_op    <= bus.alu_op;
                    bus.mem2reg   <= 1'b1;
                    bus.reg_write <= 1'b1;
                    bus.pc_write  <= 1'b1;
                    retired       <= retired + 16'd1;
                end
                WB: begin
                    if (bus.halt) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state        <= FETCH;
                        bus.imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: hand-written instruction vectors, randomized instruction stream
// checked against a table-lookup model, asynchronous reset and counter wrap sequences.
module tb_multicycle_control;
    typedef struct packed {
        logic       legal;
        logic       reg_dst;
        logic       alu_src;
        logic       ex_top;
        logic [3:0] alu_op;
    } dec_t;

    typedef struct packed {
        logic        imem_req;
        logic        pc_write;
        logic        reg_dst;
        logic        reg_write;
        logic        ex_top;
        logic        alu_src;
        logic        mem_write;
        logic        mem2reg;
        logic [3:0]  alu_op;
        logic        illegal;
        logic        busy;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rtype;
        dec_t       d;
    } ref_t;

    typedef struct {
        logic [31:0] instr;
        int          delay;
        bit          halt;
        dec_t        exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          total;
    int          bad;
    logic [15:0] exp_cnt;
    bit          in_idle;
    ref_t        ref_tab[8];
    vec_t        vecs[11];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit coin();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t d = '0;
        for (int i = 0; i < 8; i++)
            if (w[31:26] == ref_tab[i].op && (!ref_tab[i].rtype || w[5:0] == ref_tab[i].fn))
                d = ref_tab[i].d;
        return d;
    endfunction

    function automatic out_t idle_o();
        out_t o = '0;
        o.cnt = exp_cnt;
        return o;
    endfunction

    function automatic out_t fetch_o();
        out_t o = '0;
        o.imem_req = 1'b1;
        o.busy     = 1'b1;
        o.cnt      = exp_cnt;
        return o;
    endfunction

    function automatic out_t decode_o(input bit ill);
        out_t o = '0;
        o.busy     = 1'b1;
        o.illegal  = ill;
        o.pc_write = ill;
        o.cnt      = exp_cnt;
        return o;
    endfunction

    function automatic out_t exec_o(input dec_t d, input bit wb);
        out_t o = '0;
        o.busy      = 1'b1;
        o.reg_dst   = d.reg_dst;
        o.alu_src   = d.alu_src;
        o.ex_top    = d.ex_top;
        o.alu_op    = d.alu_op;
        o.mem2reg   = 1'b1;
        o.reg_write = wb;
        o.pc_write  = wb;
        o.cnt       = exp_cnt;
        return o;
    endfunction

    task automatic applyStimulus(input logic st, input logic hl, input logic v, input logic [31:0] w);
        bus.start       = st;
        bus.halt        = hl;
        bus.instr_valid = v;
        bus.instr       = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = {bus.imem_req, bus.pc_write, bus.reg_dst, bus.reg_write, bus.ex_top,
               bus.alu_src, bus.mem_write, bus.mem2reg, bus.alu_op, bus.illegal,
               bus.busy, bus.instr_cnt};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h want %h (req pcw dst rw top src mw m2r op ill busy cnt)",
                     name, $time, act, exp);
        end
    endtask

    task automatic enter_fetch(input logic v, input logic [31:0] w);
        applyStimulus(1'b1, 1'b0, v, w);
        checkOutput("start_to_fetch", fetch_o());
        in_idle = 1'b0;
    endtask

    // Drives one instruction from its first FETCH cycle to the following FETCH or IDLE.
    task automatic run_instr(input logic [31:0] w, input int delay, input bit hlt, input dec_t d);
        for (int i = 0; i < delay; i++) begin
            applyStimulus(coin(), 1'b0, 1'b0, $urandom);
            checkOutput("fetch_wait", fetch_o());
        end
        applyStimulus(coin(), 1'b0, 1'b1, w);
        checkOutput("decode", decode_o(!d.legal));
        if (!d.legal) begin
            applyStimulus(coin(), hlt, coin(), $urandom);
            checkOutput("after_illegal", hlt ? idle_o() : fetch_o());
        end else begin
            applyStimulus(coin(), 1'b0, coin(), $urandom);
            checkOutput("exec", exec_o(d, 1'b0));
            applyStimulus(coin(), 1'b0, coin(), $urandom);
            exp_cnt = exp_cnt + 16'd1;
            checkOutput("wb", exec_o(d, 1'b1));
            applyStimulus(coin(), hlt, coin(), $urandom);
            checkOutput("after_wb", hlt ? idle_o() : fetch_o());
        end
        in_idle = hlt;
    endtask

    initial begin
        logic [31:0] w;
        int          k;
        dec_t        d;

        ref_tab[0] = '{6'b000000, 6'b100000, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0010}};
        ref_tab[1] = '{6'b000000, 6'b100010, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0110}};
        ref_tab[2] = '{6'b000000, 6'b100100, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000}};
        ref_tab[3] = '{6'b000000, 6'b100101, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0001}};
        ref_tab[4] = '{6'b000000, 6'b101010, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0111}};
        ref_tab[5] = '{6'b001000, 6'b000000, 1'b0, '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0010}};
        ref_tab[6] = '{6'b011001, 6'b000000, 1'b0, '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1000}};
        ref_tab[7] = '{6'b011000, 6'b000000, 1'b0, '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1001}};

        vecs[0]  = '{32'h00430820, 0, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0010}};
        vecs[1]  = '{32'h2001FFFF, 3, 1'b0, '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0010}};
        vecs[2]  = '{32'hFC000000, 0, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}};
        vecs[3]  = '{32'h00000022, 0, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0110}};
        vecs[4]  = '{32'h0000002A, 0, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0111}};
        vecs[5]  = '{32'h64000000, 0, 1'b0, '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1000}};
        vecs[6]  = '{32'h60000000, 0, 1'b1, '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1001}};
        vecs[7]  = '{32'h00000021, 1, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}};
        vecs[8]  = '{32'h00000024, 1, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000}};
        vecs[9]  = '{32'h00000025, 2, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0001}};
        vecs[10] = '{32'h0C000020, 0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}};

        total           = 0;
        bad             = 0;
        exp_cnt         = 16'h0000;
        in_idle         = 1'b1;
        bus.start       = 1'b0;
        bus.halt        = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_state", idle_o());
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00430820);
        checkOutput("idle_hold", idle_o());
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00000022);
        checkOutput("idle_hold", idle_o());

        $display("[TB] directed vector table");
        enter_fetch(1'b1, vecs[0].instr);
        for (int i = 0; i < 11; i++) begin
            if (in_idle) enter_fetch(coin(), $urandom);
            run_instr(vecs[i].instr, vecs[i].delay, vecs[i].halt, vecs[i].exp);
        end

        $display("[TB] reset during EXEC");
        if (in_idle) enter_fetch(1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00430820);
        checkOutput("rst_decode", decode_o(1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_exec", exec_o(model_decode(32'h00430820), 1'b0));
        #2 rst_n = 1'b0;
        exp_cnt = 16'h0000;
        #1 checkOutput("async_reset", idle_o());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h00430820);
            checkOutput("post_reset_idle", idle_o());
        end
        in_idle = 1'b1;

        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 60; n++) begin
            w = $urandom;
            if (coin()) begin
                k = $urandom_range(0, 7);
                w[31:26] = ref_tab[k].op;
                if (ref_tab[k].rtype) w[5:0] = ref_tab[k].fn;
            end
            d = model_decode(w);
            if (in_idle) enter_fetch(coin(), $urandom);
            run_instr(w, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), d);
        end

        $display("[TB] counter wrap");
        if (!in_idle) run_instr(32'h00430820, 0, 1'b1, model_decode(32'h00430820));
        force dut.retired = 16'hFFFE;
        #1 release dut.retired;
        exp_cnt = 16'hFFFE;
        enter_fetch(1'b1, 32'h00430820);
        run_instr(32'h00430820, 0, 1'b0, model_decode(32'h00430820));
        run_instr(32'h00430820, 0, 1'b1, model_decode(32'h00430820));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_idle", idle_o());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
